// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: receives a framed, XOR-checksummed image byte by byte,
// writes it as little-endian 32-bit words, and holds the core in reset until the image is valid.
module im_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        WAIT_LEN,
        WAIT_DATA,
        WAIT_SUM,
        RUN,
        ERROR
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  len, len_n;
    logic [IDX_W-1:0]  word_idx, word_idx_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [7:0]        sum, sum_n;
    logic [31:0]       word, word_n;
    logic              im_we_n;
    logic [ADDR_W-1:0] im_addr_n;
    logic [31:0]       im_wdata_n;
    logic              cpu_rst_n_n, done_n, err_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_LEN;
            len       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            sum       <= '0;
            word      <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            word_idx  <= word_idx_n;
            byte_idx  <= byte_idx_n;
            sum       <= sum_n;
            word      <= word_n;
            im_we     <= im_we_n;
            im_addr   <= im_addr_n;
            im_wdata  <= im_wdata_n;
            cpu_rst_n <= cpu_rst_n_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        len_n      = len;
        word_idx_n = word_idx;
        byte_idx_n = byte_idx;
        sum_n      = sum;
        word_n     = word;
        im_we_n    = 1'b0;
        im_addr_n  = im_addr;
        im_wdata_n = im_wdata;

        // reload wins over a coincident byte, which is simply dropped
        if (reload) begin
            state_n    = WAIT_LEN;
            word_idx_n = '0;
            byte_idx_n = '0;
            sum_n      = '0;
        end else if (rx_valid) begin
            case (state)
                WAIT_LEN: begin
                    if (rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) begin
                        state_n = ERROR;
                    end else begin
                        len_n      = IDX_W'(rx_data);
                        word_idx_n = '0;
                        byte_idx_n = '0;
                        sum_n      = '0;
                        state_n    = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    word_n[{byte_idx, 3'b000} +: 8] = rx_data;
                    sum_n      = sum ^ rx_data;
                    byte_idx_n = byte_idx + 2'd1;
                    // the top byte completes the word, so write it straight from rx_data
                    if (byte_idx == 2'd3) begin
                        im_we_n    = 1'b1;
                        im_addr_n  = ADDR_W'({word_idx, 2'b00});
                        im_wdata_n = {rx_data, word[23:0]};
                        word_idx_n = word_idx + IDX_W'(1);
                        if (word_idx == len - IDX_W'(1)) begin
                            state_n = WAIT_SUM;
                        end
                    end
                end
                WAIT_SUM: begin
                    state_n = (rx_data == sum) ? RUN : ERROR;
                end
                default: begin
                end
            endcase
        end

        cpu_rst_n_n = (state_n == RUN);
        done_n      = (state_n == RUN);
        err_n       = (state_n == ERROR);
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: framing, checksum, length limits,
// reload priority and synchronous reset, with hand-computed expectations.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reload = 1'b0;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    int nAsserts = 0;
    int nFails   = 0;

    int          cycle = 0;
    logic [15:0] wrAddr [256];
    logic [31:0] wrData [256];
    int          wrCycle[256];
    int          wrCount = 0;

    im_loader #(.ADDR_W(16), .MAX_WORDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .reload    (reload),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Log every write strobe mid-cycle so a stretched pulse shows up as an extra write
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (wrCount < 256) begin
                wrAddr[wrCount]  = im_addr;
                wrData[wrCount]  = im_wdata;
                wrCycle[wrCount] = cycle;
            end
            wrCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic rl = 1'b0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        reload   = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            reload   = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseReload();
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        checkOutput({tag, "_im_we"},     32'(im_we),     32'd0);
        checkOutput({tag, "_im_addr"},   32'(im_addr),   32'd0);
        checkOutput({tag, "_im_wdata"},  im_wdata,       32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_err"},       32'(err),       32'd0);
    endtask

    function automatic logic [31:0] wordOf(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A, 8'h3C + b};
    endfunction

    initial begin
        logic [7:0]  frameA [10];
        logic [7:0]  sum;
        logic [31:0] w;
        int          badSpacing;

        frameA = '{8'h02, 8'hB7, 8'h05, 8'hF8, 8'h03, 8'h03, 8'hA8, 8'h45, 8'h01, 8'hA6};

        $display("[TB] reset");
        rst_n = 1'b0;
        idleCycles(2);
        checkResetValues("reset");
        rst_n = 1'b1;

        $display("[TB] two-word image");
        for (int i = 0; i < 5; i++) applyStimulus(frameA[i]);
        checkOutput("w0_we",   32'(im_we), 32'd1);
        checkOutput("w0_addr", 32'(im_addr), 32'h0000);
        checkOutput("w0_data", im_wdata, 32'h03F805B7);
        applyStimulus(frameA[5]);
        checkOutput("w0_we_drop",  32'(im_we), 32'd0);
        checkOutput("w0_addr_hold", 32'(im_addr), 32'h0000);
        for (int i = 6; i < 9; i++) applyStimulus(frameA[i]);
        checkOutput("w1_we",   32'(im_we), 32'd1);
        checkOutput("w1_addr", 32'(im_addr), 32'h0004);
        checkOutput("w1_data", im_wdata, 32'h0145A803);
        checkOutput("w1_cpu_held", 32'(cpu_rst_n), 32'd0);
        applyStimulus(frameA[9]);
        checkOutput("rel_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("rel_done", 32'(done), 32'd1);
        checkOutput("rel_err",  32'(err), 32'd0);
        checkOutput("rel_we",   32'(im_we), 32'd0);
        idleCycles(2);
        checkOutput("run_done_holds", 32'(done), 32'd1);
        checkOutput("a_wr_count", 32'(wrCount), 32'd2);
        checkOutput("a_wr_spacing", 32'(wrCycle[1] - wrCycle[0]), 32'd4);

        $display("[TB] reload from run, bad checksum");
        pulseReload();
        checkOutput("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("reload_done", 32'(done), 32'd0);
        wrCount = 0;
        for (int i = 0; i < 9; i++) applyStimulus(frameA[i]);
        applyStimulus(8'hA7);
        checkOutput("badsum_err", 32'(err), 32'd1);
        checkOutput("badsum_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("badsum_done", 32'(done), 32'd0);
        checkOutput("badsum_wr_count", 32'(wrCount), 32'd2);
        for (int i = 0; i < 5; i++) applyStimulus(frameA[i]);
        idleCycles(1);
        checkOutput("err_ignores_bytes_wr", 32'(wrCount), 32'd2);
        checkOutput("err_sticky", 32'(err), 32'd1);
        pulseReload();
        checkOutput("err_reload_clear", 32'(err), 32'd0);

        $display("[TB] length limits");
        wrCount = 0;
        applyStimulus(8'h00);
        checkOutput("len0_err", 32'(err), 32'd1);
        applyStimulus(8'h01);
        applyStimulus(8'h13);
        idleCycles(2);
        checkOutput("len0_no_write", 32'(wrCount), 32'd0);
        pulseReload();
        checkOutput("len0_reload_err", 32'(err), 32'd0);
        applyStimulus(8'h41);
        checkOutput("len65_err", 32'(err), 32'd1);
        checkOutput("len65_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        idleCycles(2);
        checkOutput("len65_no_write", 32'(wrCount), 32'd0);
        pulseReload();
        checkOutput("len65_reload_err", 32'(err), 32'd0);

        $display("[TB] max-length image back to back");
        wrCount = 0;
        sum = 8'h00;
        applyStimulus(8'h40);
        for (int i = 0; i < 64; i++) begin
            w = wordOf(i);
            for (int j = 0; j < 4; j++) begin
                sum = sum ^ w[8*j +: 8];
                applyStimulus(w[8*j +: 8]);
            end
        end
        checkOutput("max_pre_sum_done", 32'(done), 32'd0);
        applyStimulus(sum);
        checkOutput("max_done", 32'(done), 32'd1);
        checkOutput("max_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("max_err", 32'(err), 32'd0);
        idleCycles(2);
        checkOutput("max_wr_count", 32'(wrCount), 32'd64);
        badSpacing = 0;
        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("max_addr_%0d", i), 32'(wrAddr[i]), 32'(i * 4));
            checkOutput($sformatf("max_data_%0d", i), wrData[i], wordOf(i));
            if (i > 0 && wrCycle[i] - wrCycle[i-1] != 4) badSpacing++;
        end
        checkOutput("max_spacing_errors", 32'(badSpacing), 32'd0);

        $display("[TB] reload colliding with payload byte");
        pulseReload();
        checkOutput("run_reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("run_reload_done", 32'(done), 32'd0);
        wrCount = 0;
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33, 1'b1);
        checkOutput("collide_we", 32'(im_we), 32'd0);
        checkOutput("collide_err", 32'(err), 32'd0);
        checkOutput("collide_done", 32'(done), 32'd0);
        applyStimulus(8'h01);
        applyStimulus(8'h13);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkOutput("fresh_we", 32'(im_we), 32'd1);
        checkOutput("fresh_addr", 32'(im_addr), 32'h0000);
        checkOutput("fresh_data", im_wdata, 32'h00000013);
        applyStimulus(8'h13);
        checkOutput("fresh_done", 32'(done), 32'd1);
        checkOutput("fresh_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        idleCycles(1);
        checkOutput("fresh_wr_count", 32'(wrCount), 32'd1);

        $display("[TB] synchronous reset mid-frame");
        pulseReload();
        applyStimulus(8'h03);
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i));
        checkOutput("mid_addr", 32'(im_addr), 32'h0004);
        checkOutput("mid_data", im_wdata, 32'h08070605);
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h0A;
        @(posedge clk);
        #1;
        checkResetValues("midreset");
        rst_n = 1'b1;
        applyStimulus(8'h01);
        applyStimulus(8'h13);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h13);
        checkOutput("post_reset_done", 32'(done), 32'd1);
        idleCycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
